// File: rtl/iir_stream_adapter_pkg.sv
// Shared definitions for the IIR biquad stream adapter and its filter-side benches.
// State encoding, default sample width and the filter response latency live here.
package iir_stream_adapter_pkg;

    localparam int SAMPLE_W       = 18;
    localparam int FILTER_LATENCY = 6;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/iir_result_fifo.sv
// Circular-buffer result FIFO with first-word fall-through head and occupancy count.
// The head reads as zero while empty so downstream never sees stale data.
module iir_result_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // A pop frees the head slot in the same cycle, so push-at-full is legal alongside it.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iir_stream_adapter.sv
// Initiator for the multi-cycle IIR biquad: one sample in flight, results buffered
// in a small FIFO, credit-gated upstream ready and a sticky watchdog timeout flag.
//
// state | meaning
// IDLE  | s_ready = credit_ok; latch accepted sample into hold
// ISSUE | one-cycle f_din_valid pulse, watchdog cleared
// WAIT  | watchdog counting; f_dout_valid pushes result, timeout sets err
module iir_stream_adapter
    import iir_stream_adapter_pkg::*;
#(
    parameter int DW      = SAMPLE_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] f_din,
    output logic          f_din_valid,
    input  logic [DW-1:0] f_dout,
    input  logic          f_dout_valid,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          err,
    output logic [15:0]   sample_cnt
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int CW  = $clog2(DEPTH) + 1;

    state_t          state;
    logic [DW-1:0]   hold;
    logic [WDW-1:0]  wdog;
    logic            out_of_rst;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            credit_ok;
    logic            accept;
    logic            push;
    logic            pop;
    logic            timeout;

    assign credit_ok   = (fifo_count < CW'(DEPTH));
    // out_of_rst keeps s_ready low while rst is held, so every output reads 0 in reset.
    assign s_ready     = out_of_rst && (state == ST_IDLE) && credit_ok;
    assign accept      = s_valid && s_ready;
    assign f_din       = hold;
    assign f_din_valid = (state == ST_ISSUE);
    assign m_valid     = !fifo_empty;
    assign pop         = m_valid && m_ready;
    assign push        = (state == ST_WAIT) && f_dout_valid && (!fifo_full || pop);
    assign timeout     = (state == ST_WAIT) && !f_dout_valid && (wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            hold       <= '0;
            wdog       <= '0;
            err        <= 1'b0;
            sample_cnt <= '0;
            out_of_rst <= 1'b0;
        end else begin
            out_of_rst <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold  <= s_data;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (push) begin
                        sample_cnt <= sample_cnt + 16'd1;
                        state      <= ST_IDLE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    iir_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (f_dout),
        .pop   (pop),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_iir_stream_adapter.sv
// Directed bench for iir_stream_adapter with a behavioural filter and a result scoreboard.
module tb_iir_stream_adapter;
    import iir_stream_adapter_pkg::*;

    localparam int DW      = 18;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int M_BIQ   = 0;
    localparam int M_XOR   = 1;
    localparam int M_MUTE  = 2;
    localparam int B0      = 790;
    localparam int B1      = -196;
    localparam logic [DW-1:0] XMASK = 18'h15A5A;
    localparam logic [DW-1:0] Y0    = 18'd771;
    localparam logic [DW-1:0] Y1    = 18'h3FF40;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] f_din;
    logic          f_din_valid;
    logic [DW-1:0] f_dout;
    logic          f_dout_valid;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          err;
    logic [15:0]   sample_cnt;

    logic          fm_valid, fm_pend, spur_valid;
    logic [DW-1:0] fm_data, fm_x, fm_x1, spur_data;
    int            fm_cnt;
    int            mode;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] last_acc_data, ref_x1;
    logic          prev_fdv;
    bit            gap_chk;
    int            cyc, n_acc, last_acc_cyc, pulse_cyc, cnt0, n;
    int            err_cyc = -1;
    int            checks, failures;

    iir_stream_adapter #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .f_din        (f_din),
        .f_din_valid  (f_din_valid),
        .f_dout       (f_dout),
        .f_dout_valid (f_dout_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .err          (err),
        .sample_cnt   (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_out(input logic [DW-1:0] x, input logic [DW-1:0] x1,
                                                input int m);
        int acc;
        if (m == M_BIQ) begin
            acc = B0 * int'($signed(x)) + B1 * int'($signed(x1));
            return DW'(acc >>> 10);
        end
        return x ^ XMASK;
    endfunction

    // Filter answers FILTER_LATENCY cycles after the issue pulse unless muted.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fm_valid <= 1'b0;
            fm_data  <= '0;
            fm_pend  <= 1'b0;
            fm_cnt   <= 0;
            fm_x     <= '0;
            fm_x1    <= '0;
        end else begin
            fm_valid <= 1'b0;
            if (f_din_valid) begin
                fm_pend <= 1'b1;
                fm_cnt  <= FILTER_LATENCY - 1;
                fm_x    <= f_din;
            end else if (fm_pend) begin
                fm_cnt <= fm_cnt - 1;
                if (fm_cnt == 1) begin
                    fm_pend <= 1'b0;
                    if (mode != M_MUTE) begin
                        fm_valid <= 1'b1;
                        fm_data  <= model_out(fm_x, fm_x1, mode);
                        fm_x1    <= fm_x;
                    end
                end
            end
        end
    end

    assign f_dout_valid = fm_valid | spur_valid;
    assign f_dout       = spur_valid ? spur_data : fm_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        cyc++;
        if (m_valid && m_ready) begin
            check("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0]);
                void'(exp_q.pop_front());
                out_log.push_back(m_data);
            end
        end
        if (f_din_valid) begin
            check("pulse_1cyc", prev_fdv, 0);
            check("issue_lat", cyc - last_acc_cyc, 1);
            check("f_din_hold", f_din, last_acc_data);
            pulse_cyc = cyc;
        end
        prev_fdv = f_din_valid;
        if (err && err_cyc < 0) err_cyc = cyc;
        if (s_valid && s_ready) begin
            if (gap_chk && n_acc > 0) check("accept_gap", cyc - last_acc_cyc, 8);
            n_acc++;
            last_acc_cyc  = cyc;
            last_acc_data = s_data;
            void'(in_q.pop_front());
            if (mode == M_BIQ) begin
                exp_q.push_back(model_out(s_data, ref_x1, mode));
                ref_x1 = s_data;
            end else if (mode == M_XOR) begin
                exp_q.push_back(s_data ^ XMASK);
            end
        end
        @(negedge clk);
        s_valid = (in_q.size() != 0);
        s_data  = s_valid ? in_q[0] : '0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        check(tag, k < budget, 1);
    endtask

    task automatic do_reset();
        in_q.delete();
        exp_q.delete();
        ref_x1  = '0;
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; n_acc = 0; last_acc_cyc = 0; pulse_cyc = 0;
        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        spur_valid = 1'b0; spur_data = '0; mode = M_BIQ; gap_chk = 1'b0;
        ref_x1 = '0; last_acc_data = '0; prev_fdv = 1'b0;

        @(negedge clk); @(negedge clk); #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_f_din_valid", f_din_valid, 0);
        check("rst_f_din", f_din, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err", err, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(); tick();
        check("ready_after_rst", s_ready, 1);

        // Impulse through the biquad model
        mode = M_BIQ; m_ready = 1'b1; out_log.delete();
        in_q.push_back(18'd1000); in_q.push_back(18'd0); in_q.push_back(18'd0);
        drain("t1_drain", 100);
        check("t1_n_out", out_log.size(), 3);
        if (out_log.size() >= 2) begin
            check("t1_y0", out_log[0], Y0);
            check("t1_y1", out_log[1], Y1);
        end
        check("t1_cnt", sample_cnt, 3);

        // Continuous stream, one accept every 8 cycles
        do_reset();
        mode = M_XOR; gap_chk = 1'b1; n_acc = 0;
        for (int i = 0; i < 10; i++) in_q.push_back(DW'($urandom));
        drain("t2_drain", 200);
        gap_chk = 1'b0;
        check("t2_nacc", n_acc, 10);
        check("t2_cnt", sample_cnt, 10);

        // Backpressure fills the FIFO, then releases
        m_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 6; i++) in_q.push_back(DW'($urandom));
        repeat (60) tick();
        check("t3_nacc_full", n_acc, 4);
        check("t3_s_ready", s_ready, 0);
        check("t3_m_valid", m_valid, 1);
        check("t3_cnt_full", sample_cnt, 14);
        m_ready = 1'b1;
        drain("t3_drain", 200);
        check("t3_nacc_all", n_acc, 6);
        check("t3_cnt_all", sample_cnt, 16);

        // Muted filter trips the watchdog
        mode = M_MUTE; cnt0 = sample_cnt; err_cyc = -1;
        in_q.push_back(18'd123);
        n = 0;
        while (err_cyc < 0 && n < 100) begin tick(); n++; end
        check("t4_err_seen", n < 100, 1);
        check("t4_err_timing", err_cyc - pulse_cyc, TIMEOUT + 1);
        check("t4_no_push", sample_cnt, cnt0);
        check("t4_m_valid", m_valid, 0);
        check("t4_idle", s_ready, 1);
        mode = M_XOR;
        in_q.push_back(18'h2ABCD);
        drain("t4_recover", 100);
        check("t4_cnt_after", sample_cnt, cnt0 + 1);
        check("t4_err_sticky", err, 1);

        // Reset in WAIT with two results buffered
        m_ready = 1'b0; n_acc = 0; cnt0 = sample_cnt;
        for (int i = 0; i < 3; i++) in_q.push_back(DW'($urandom));
        n = 0;
        while (n_acc < 3 && n < 100) begin tick(); n++; end
        check("t5_accepts", n < 100, 1);
        repeat (3) tick();
        check("t5_two_held", sample_cnt, cnt0 + 2);
        check("t5_m_valid_pre", m_valid, 1);
        in_q.delete(); exp_q.delete(); ref_x1 = '0;
        rst = 1'b0;
        tick();
        check("t5_m_valid_rst", m_valid, 0);
        check("t5_cnt_rst", sample_cnt, 0);
        check("t5_err_rst", err, 0);
        rst = 1'b1;
        tick(); tick();
        check("t5_s_ready", s_ready, 1);
        check("t5_m_valid_post", m_valid, 0);
        m_ready = 1'b1;
        in_q.push_back(18'h1F00F);
        drain("t5_after", 100);
        check("t5_cnt_after", sample_cnt, 1);

        // Spurious filter strobe while idle
        m_ready = 1'b0; cnt0 = sample_cnt;
        spur_data = 18'h11111; spur_valid = 1'b1;
        tick();
        spur_valid = 1'b0;
        repeat (3) tick();
        check("t6_m_valid", m_valid, 0);
        check("t6_cnt", sample_cnt, cnt0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
